// File: rtl/aes_128_pkg.sv
// Shared AES-128 constants, control/update encodings and GF(2^8) helpers
// used by the inverse cipher datapath.
package aes_128_pkg;

  localparam int AES128_ROUNDS = 10;

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_INIT,
    CTRL_SBOX,
    CTRL_MAIN
  } ctrl_state_e;

  typedef enum logic [2:0] {
    UPD_NO,
    UPD_INIT,
    UPD_SBOX,
    UPD_MAIN,
    UPD_FINAL
  } upd_type_e;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // c is one of 4'h9/4'hb/4'hd/4'he; each set bit adds op*{1,2,4,8}.
  function automatic logic [7:0] gm_mul(input logic [7:0] op, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = gm2(op);
    x4 = gm2(x2);
    x8 = gm2(x4);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
           (c[1] ? x2 : 8'h00) ^ (c[0] ? op : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gm_mul(a0, 4'he) ^ gm_mul(a1, 4'hb) ^ gm_mul(a2, 4'hd) ^ gm_mul(a3, 4'h9),
            gm_mul(a0, 4'h9) ^ gm_mul(a1, 4'he) ^ gm_mul(a2, 4'hb) ^ gm_mul(a3, 4'hd),
            gm_mul(a0, 4'hd) ^ gm_mul(a1, 4'h9) ^ gm_mul(a2, 4'he) ^ gm_mul(a3, 4'hb),
            gm_mul(a0, 4'hb) ^ gm_mul(a1, 4'hd) ^ gm_mul(a2, 4'h9) ^ gm_mul(a3, 4'he)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = s;
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

endpackage

// File: rtl/aes_128_inv_sbox.sv
// Four parallel AES inverse S-box byte lookups on one 32-bit word.
module aes_128_inv_sbox (
  input  logic [31:0] sword_i,
  output logic [31:0] new_sword_o
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign new_sword_o = {INV_SBOX[sword_i[31:24]], INV_SBOX[sword_i[23:16]],
                        INV_SBOX[sword_i[15:8]],  INV_SBOX[sword_i[7:0]]};

endmodule

// File: rtl/aes_128_decipher_block.sv
// Iterative AES-128 inverse cipher, one inverse S-box word per cycle.
// Define AES_DEC_PARALLEL_SBOX_EN to substitute all four words in one cycle.
//
// state     | meaning
// ----------+---------------------------------------------------------
// CTRL_IDLE | result valid (ready=1), wait for next
// CTRL_INIT | AddRoundKey(round 10) + InvShiftRows of the input block
// CTRL_SBOX | InvSubBytes, word w[sword_ctr] (all four in parallel build)
// CTRL_MAIN | AddRoundKey + InvMixColumns + InvShiftRows, or final AddRoundKey
module aes_128_decipher_block
  import aes_128_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [3:0]   round,
  output logic [127:0] new_block,
  output logic         ready
);

`ifdef AES_DEC_PARALLEL_SBOX_EN
  localparam logic [1:0] SWORD_LAST = 2'd0;
`else
  localparam logic [1:0] SWORD_LAST = 2'd3;
`endif

  ctrl_state_e  state_q, state_d;
  upd_type_e    upd;
  logic [31:0]  w_q [4];
  logic [3:0]   w_we;
  logic [3:0]   round_q, round_d;
  logic [1:0]   sword_ctr_q, sword_ctr_d;
  logic         ready_q, ready_d;
  logic [127:0] state_blk, upd_blk;

  assign state_blk = {w_q[0], w_q[1], w_q[2], w_q[3]};

`ifdef AES_DEC_PARALLEL_SBOX_EN
  logic [127:0] sub_blk;
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_128_inv_sbox u_inv_sbox (
      .sword_i     (state_blk[127-32*i -: 32]),
      .new_sword_o (sub_blk[127-32*i -: 32])
    );
  end
`else
  logic [31:0] sbox_out;
  aes_128_inv_sbox u_inv_sbox (
    .sword_i     (w_q[sword_ctr_q]),
    .new_sword_o (sbox_out)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CTRL_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_IDLE: if (next) state_d = CTRL_INIT;
      CTRL_INIT: state_d = CTRL_SBOX;
      CTRL_SBOX: if (sword_ctr_q == SWORD_LAST) state_d = CTRL_MAIN;
      CTRL_MAIN: state_d = (round_q == 4'd0) ? CTRL_IDLE : CTRL_SBOX;
      default:   state_d = CTRL_IDLE;
    endcase
  end

  always_comb begin
    upd         = UPD_NO;
    round_d     = round_q;
    sword_ctr_d = sword_ctr_q;
    ready_d     = ready_q;
    case (state_q)
      CTRL_IDLE: begin
        if (next) begin
          round_d = 4'(NUM_ROUNDS);
          ready_d = 1'b0;
        end
      end
      CTRL_INIT: begin
        upd         = UPD_INIT;
        round_d     = round_q - 4'd1;
        sword_ctr_d = 2'd0;
      end
      CTRL_SBOX: begin
        upd         = UPD_SBOX;
        sword_ctr_d = (sword_ctr_q == SWORD_LAST) ? 2'd0 : sword_ctr_q + 2'd1;
      end
      CTRL_MAIN: begin
        if (round_q == 4'd0) begin
          upd     = UPD_FINAL;
          ready_d = 1'b1;
        end else begin
          upd         = UPD_MAIN;
          round_d     = round_q - 4'd1;
          sword_ctr_d = 2'd0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    upd_blk = state_blk;
    w_we    = 4'b0000;
    case (upd)
      UPD_INIT: begin
        upd_blk = inv_shift_rows(block ^ round_key);
        w_we    = 4'b1111;
      end
      UPD_SBOX: begin
`ifdef AES_DEC_PARALLEL_SBOX_EN
        upd_blk = sub_blk;
        w_we    = 4'b1111;
`else
        upd_blk           = {4{sbox_out}};
        w_we[sword_ctr_q] = 1'b1;
`endif
      end
      UPD_MAIN: begin
        upd_blk = inv_shift_rows(inv_mix_columns(state_blk ^ round_key));
        w_we    = 4'b1111;
      end
      UPD_FINAL: begin
        upd_blk = state_blk ^ round_key;
        w_we    = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_q     <= 4'd0;
      sword_ctr_q <= 2'd0;
      ready_q     <= 1'b1;
      for (int i = 0; i < 4; i++) w_q[i] <= 32'h0;
    end else begin
      round_q     <= round_d;
      sword_ctr_q <= sword_ctr_d;
      ready_q     <= ready_d;
      for (int i = 0; i < 4; i++) begin
        if (w_we[i]) w_q[i] <= upd_blk[127-32*i -: 32];
      end
    end
  end

  assign round     = round_q;
  assign new_block = state_blk;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_128_decipher_block.sv
// Directed FIPS-197 vectors against aes_128_decipher_block; the key memory is
// modelled here with its own S-box (GF inverse + affine) and key expansion.
module tb_aes_128_decipher_block;

`ifdef AES_DEC_PARALLEL_SBOX_EN
  localparam int LAT = 21;
  localparam int PER = 2;
`else
  localparam int LAT = 51;
  localparam int PER = 5;
`endif
  localparam int BUSY2 = (LAT > 33) ? 30 : LAT - 3;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         next = 1'b0;
  logic [127:0] block = '0;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic [127:0] new_block;
  logic         ready;

  logic         key_sel = 1'b0;
  logic [127:0] rk_c1 [0:15];
  logic [127:0] rk_b  [0:15];
  logic [7:0]   sbox_tab [0:255];
  int errors = 0;
  int checks = 0;

  aes_128_decipher_block dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .round_key (round_key),
    .block     (block),
    .round     (round),
    .new_block (new_block),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  assign round_key = key_sel ? rk_b[round] : rk_c1[round];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) if (gf_mul(a, 8'(x)) == 8'h01) inv = 8'(x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] key, input bit sel);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
            ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (sel) rk_b[r] = '0; else rk_c1[r] = '0;
    end
    for (int r = 0; r <= 10; r++) begin
      if (sel) rk_b[r]  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else     rk_c1[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Pulse next for one edge; returns at the falling edge after the start edge.
  task automatic start_op(input bit ks, input logic [127:0] blk);
    @(negedge clk);
    key_sel = ks;
    block   = blk;
    next    = 1'b1;
    @(negedge clk);
    next = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    next    = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (round !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d want 0", round); end
    checks++; if (new_block !== 128'h0) begin errors++; $display("FAIL reset_block: got %h want 0", new_block); end
  endtask

  task automatic test_fips_c1();
    int lat;
    start_op(1'b0, CT_C1);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL c1_busy: got ready=%b want 0", ready); end
    wait_ready(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL c1_latency: got %0d want %0d", lat, LAT); end
    checks++; if (new_block !== PT_C1) begin errors++; $display("FAIL c1_plaintext: got %h want %h", new_block, PT_C1); end
  endtask

  task automatic test_app_b();
    int lat;
    start_op(1'b1, CT_B);
    checks++; if (round !== 4'd10) begin errors++; $display("FAIL b_round_init: got %0d want 10", round); end
    lat = -1;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
      if (k % PER == 0) begin
        checks++;
        if (round !== 4'(10 - k / PER)) begin
          errors++;
          $display("FAIL b_round_seq k=%0d: got %0d want %0d", k, round, 10 - k / PER);
        end
      end
    end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b_latency: got %0d want %0d", lat, LAT); end
    checks++; if (new_block !== PT_B) begin errors++; $display("FAIL b_plaintext: got %h want %h", new_block, PT_B); end
    checks++; if (round !== 4'd0) begin errors++; $display("FAIL b_round_done: got %0d want 0", round); end
  endtask

  task automatic test_reset_abort();
    int lat;
    start_op(1'b0, CT_C1);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready); end
    checks++; if (round !== 4'd0) begin errors++; $display("FAIL abort_round: got %0d want 0", round); end
    checks++; if (new_block !== 128'h0) begin errors++; $display("FAIL abort_block: got %h want 0", new_block); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_op(1'b0, CT_C1);
    wait_ready(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL abort_restart_latency: got %0d want %0d", lat, LAT); end
    checks++; if (new_block !== PT_C1) begin errors++; $display("FAIL abort_restart_pt: got %h want %h", new_block, PT_C1); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    start_op(1'b0, CT_C1);
    lat = -1;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
      next = (k == 5 || k == BUSY2);
    end
    next = 1'b0;
    checks++; if (lat !== LAT) begin errors++; $display("FAIL busy_latency: got %0d want %0d", lat, LAT); end
    checks++; if (new_block !== PT_C1) begin errors++; $display("FAIL busy_plaintext: got %h want %h", new_block, PT_C1); end
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_no_restart: got ready=%b want 1", ready); end
    checks++; if (new_block !== PT_C1) begin errors++; $display("FAIL busy_hold: got %h want %h", new_block, PT_C1); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    key_sel = 1'b0;
    block   = CT_C1;
    next    = 1'b1;
    @(negedge clk);
    wait_ready(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT); end
    checks++; if (new_block !== PT_C1) begin errors++; $display("FAIL b2b_first_pt: got %h want %h", new_block, PT_C1); end
    key_sel = 1'b1;
    block   = CT_B;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_restart: got ready=%b want 0", ready); end
    checks++; if (round !== 4'd10) begin errors++; $display("FAIL b2b_round: got %0d want 10", round); end
    next = 1'b0;
    wait_ready(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT); end
    checks++; if (new_block !== PT_B) begin errors++; $display("FAIL b2b_second_pt: got %h want %h", new_block, PT_B); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    expand_key(KEY_C1, 1'b0);
    expand_key(KEY_B, 1'b1);
    test_reset();
    test_fips_c1();
    test_app_b();
    test_reset_abort();
    test_busy_ignore();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_128_decipher_block.md
Name: aes_128_decipher_block

Overview:
Iterative AES-128 inverse cipher (FIPS-197 InvCipher) datapath and control. It is the decryption counterpart of the encipher block.
It takes a 128-bit ciphertext and a round key, selected per round by the external key memory through the round output, and produces the plaintext in new_block.
It sits beside the key memory in the AES core and owns an internal inverse S-box, processing one 32-bit word per cycle.

Parameters:
NUM_ROUNDS, 10, number of AES rounds (AES-128); round counter start value.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
next  input  1  start pulse; sampled only in IDLE
round_key  input  128  round key for the current round index, driven combinationally by the key memory
block  input  128  ciphertext; sampled in INIT
round  output  4  current round index, used to address the key memory
new_block  output  128  state register {w0,w1,w2,w3}; holds the plaintext when ready=1
ready  output  1  1 = idle and result valid

Behaviour:
- Reset (async, reset_n=0): w0..w3=0, round=0, sword_ctr=0, ready=1, FSM=IDLE. Reset mid-operation aborts immediately with the same values; no partial result is retained.
- State is four 32-bit word registers w0..w3 with individual write enables. Byte order: w0=[127:96], MSB byte = row 0.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - next=1 -> round<=NUM_ROUNDS, ready<=0, go INIT.
  - next=0 -> hold.
- INIT:
  - state <= InvShiftRows(block ^ round_key), using the round-10 key.
  - round<=round-1, sword_ctr<=0, go SBOX.
- SBOX:
  - Word w[sword_ctr] is replaced by InvSubBytes of that word; one word per cycle.
  - sword_ctr increments each cycle.
  - When sword_ctr==3 at the edge, go MAIN; sword_ctr wraps to 0.
- MAIN, round>0:
  - state <= InvShiftRows(InvMixColumns(state ^ round_key)).
  - round<=round-1, sword_ctr<=0, go SBOX.
- MAIN, round==0:
  - state <= state ^ round_key (final AddRoundKey, round-0 key).
  - ready<=1, go IDLE. round stays 0.
- Latency: next sampled at edge N -> ready=0 from N, INIT at N+1, each of 10 rounds takes 4 SBOX + 1 MAIN edges -> ready=1 and new_block valid after edge N+51.
- Any next asserted while ready=0 is ignored, not queued. next held high in IDLE restarts on the next edge.
- block and round_key must be stable only during the cycle they are used. new_block is not cleared at start; it shows intermediate state while busy.
- round is monotonically decreasing 10..0 during an operation and never wraps below 0.
- InvMixColumns per column uses multipliers {0e},{0b},{0d},{09}, built from repeated xtime (GF(2^8), poly 0x11b).

Optional Feature:
AES_DEC_PARALLEL_SBOX_EN:
- Defined: four inverse S-box word instances; SBOX substitutes all four words in a single cycle and sword_ctr is unused (held 0). Latency becomes N+21 (INIT + 10 × (1 SBOX + 1 MAIN)).
- Undefined: single inverse S-box instance, word-serial, latency N+51 as above.
- Results must be bit-identical in both builds.

Decomposition:
- Shared package aes_128_pkg:
  - NUM_ROUNDS/AES128_ROUNDS constant.
  - FSM state encodings: CTRL_IDLE/INIT/SBOX/MAIN.
  - Update-type codes: NO/INIT/SBOX/MAIN/FINAL.
  - gm2 helper and a gm_mul(op, const) helper for 09/0b/0d/0e.
- Sub-module aes_128_inv_sbox: 32-bit word in/out, four combinational 256-entry inverse S-box lookups. Shared with any future key-expansion reuse.

Test Plan:
1. FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench model supplies round keys by round, round10 = 13111d7fe3944a17f307a78b4d2b30c5), block=69c4e0d86a7b0430d8cdb78070b4c55a, next pulse -> ready low for 51 cycles, then new_block=00112233445566778899aabbccddeeff.
2. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, block=3925841d02dc09fbdc118597196a0b32 -> new_block=3243f6a8885a308d313198a2e0370734. Check round sequence 10,9,…,0 at INIT/MAIN cycles.
3. Reset values and mid-operation abort:
   - Release reset -> ready=1, round=0, new_block=0.
   - Start case 1, assert reset_n=0 at cycle 20 -> immediate ready=1, round=0, new_block=0.
   - Restart -> correct result.
4. Busy-ignore: pulse next again at cycles 5 and 30 of an operation -> no restart, result and latency identical to case 1, ready toggles only once.
5. Back-to-back: next held high continuously for case 1 then App. B block swapped on the ready edge -> second operation starts the edge after ready=1 and both results are correct.
6. Build with AES_DEC_PARALLEL_SBOX_EN and rerun cases 1 and 2 -> same plaintexts, ready after 21 cycles.
